// File: rtl/pipe_stage_latch.sv
// pipe_stage_latch: parametrised inter-stage pipeline latch.
// Carries an instruction word, NUM_WORDS payload words and a destination
// register index between two pipeline stages using a valid/ready handshake.
// All state updates on the falling edge of clk, matching the processor's
// latch convention. Reset is synchronous, active-high, sampled on that edge.
//
// Optional feature macro: PIPE_LATCH_SKID_EN
//   undefined : single entry; in_ready = out_ready | ~out_valid (combinational)
//   defined   : adds a skid entry; in_ready = ~skid_valid (registered)
//
// Invariant: whenever an entry is not valid its payload registers hold zero,
// so an empty output looks like a NOP (IR=0, wC=0).
module pipe_stage_latch #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_WORDS = 2,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_ir,
  input  logic [NUM_WORDS*DATA_W-1:0]   in_words,
  input  logic [REG_W-1:0]              in_wc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_ir,
  output logic [NUM_WORDS*DATA_W-1:0]   out_words,
  output logic [REG_W-1:0]              out_wc,
  output logic [CNT_W-1:0]              bubble_count
);

  localparam int unsigned PW = NUM_WORDS * DATA_W;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Main (output-facing) entry
  logic              r_out_valid;
  logic [DATA_W-1:0] r_ir;
  logic [PW-1:0]     r_words;
  logic [REG_W-1:0]  r_wc;
  logic [CNT_W-1:0]  r_bubble_count;

  logic              w_in_fire;

  assign out_valid    = r_out_valid;
  assign out_ir       = r_ir;
  assign out_words    = r_words;
  assign out_wc       = r_wc;
  assign bubble_count = r_bubble_count;

  assign w_in_fire = in_valid & in_ready;

  // Saturating count of edges where downstream was ready but got nothing
  always_ff @(negedge clk) begin
    if (reset) begin
      r_bubble_count <= '0;
    end else if (out_ready && !r_out_valid && (r_bubble_count != '1)) begin
      r_bubble_count <= r_bubble_count + CNT_ONE;
    end
  end

`ifdef PIPE_LATCH_SKID_EN

  // Skid entry: catches one upstream entry while main is stalled
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_ir;
  logic [PW-1:0]     r_skid_words;
  logic [REG_W-1:0]  r_skid_wc;
  logic              w_out_fire;
  logic              w_main_free;

  // in_ready depends only on registered state, breaking the ready path
  assign in_ready    = ~r_skid_valid;
  assign w_out_fire  = r_out_valid & out_ready;
  assign w_main_free = ~r_out_valid | w_out_fire;

  // Two-entry FIFO: main refills from skid first so ordering is preserved;
  // skid is only ever occupied while main is valid.
  always_ff @(negedge clk) begin
    if (reset || flush) begin
      r_out_valid  <= 1'b0;
      r_ir         <= '0;
      r_words      <= '0;
      r_wc         <= '0;
      r_skid_valid <= 1'b0;
      r_skid_ir    <= '0;
      r_skid_words <= '0;
      r_skid_wc    <= '0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        r_out_valid <= 1'b1;
        r_ir        <= r_skid_ir;
        r_words     <= r_skid_words;
        r_wc        <= r_skid_wc;
        if (w_in_fire) begin
          r_skid_ir    <= in_ir;
          r_skid_words <= in_words;
          r_skid_wc    <= in_wc;
        end else begin
          r_skid_valid <= 1'b0;
          r_skid_ir    <= '0;
          r_skid_words <= '0;
          r_skid_wc    <= '0;
        end
      end else begin
        r_out_valid <= w_in_fire;
        r_ir        <= w_in_fire ? in_ir    : '0;
        r_words     <= w_in_fire ? in_words : '0;
        r_wc        <= w_in_fire ? in_wc    : '0;
      end
    end else if (w_in_fire) begin
      r_skid_valid <= 1'b1;
      r_skid_ir    <= in_ir;
      r_skid_words <= in_words;
      r_skid_wc    <= in_wc;
    end
  end

`else

  // Accept whenever the held entry leaves or there is none
  assign in_ready = out_ready | ~r_out_valid;

  // Single-entry latch: load or bubble when ready, hold on stall
  always_ff @(negedge clk) begin
    if (reset || flush) begin
      r_out_valid <= 1'b0;
      r_ir        <= '0;
      r_words     <= '0;
      r_wc        <= '0;
    end else if (in_ready) begin
      r_out_valid <= w_in_fire;
      r_ir        <= w_in_fire ? in_ir    : '0;
      r_words     <= w_in_fire ? in_words : '0;
      r_wc        <= w_in_fire ? in_wc    : '0;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Testbench for pipe_stage_latch (default build or PIPE_LATCH_SKID_EN).
module tb_pipe_stage_latch;

  localparam int unsigned DW = 32;
  localparam int unsigned NW = 2;
  localparam int unsigned RW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT signals
  logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0]     in_ir, out_ir;
  logic [NW*DW-1:0]  in_words, out_words;
  logic [RW-1:0]     in_wc, out_wc;
  logic [15:0]       bubble_count;

  // Saturation DUT signals (CNT_W = 4)
  logic              s_reset, s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [DW-1:0]     s_in_ir, s_out_ir;
  logic [NW*DW-1:0]  s_in_words, s_out_words;
  logic [RW-1:0]     s_in_wc, s_out_wc;
  logic [3:0]        s_bubble;

  pipe_stage_latch #(.DATA_W(DW), .NUM_WORDS(NW), .REG_W(RW), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ir(in_ir), .in_words(in_words), .in_wc(in_wc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ir(out_ir), .out_words(out_words), .out_wc(out_wc),
    .bubble_count(bubble_count)
  );

  pipe_stage_latch #(.DATA_W(DW), .NUM_WORDS(NW), .REG_W(RW), .CNT_W(4)) u_sat (
    .clk(clk), .reset(s_reset), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_ir(s_in_ir), .in_words(s_in_words), .in_wc(s_in_wc),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_ir(s_out_ir), .out_words(s_out_words), .out_wc(s_out_wc),
    .bubble_count(s_bubble)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One active (falling) edge, then settle before sampling
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] w0,
                       input logic [31:0] w1, input logic [4:0] wc);
    in_valid = v;
    in_ir    = ir;
    in_words = {w1, w0};
    in_wc    = wc;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] ir,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [4:0] wc, input logic [15:0] bub);
    check({tag, ".valid"}, 64'(out_valid), 64'(v));
    check({tag, ".ir"},    64'(out_ir), 64'(ir));
    check({tag, ".w0"},    64'(out_words[31:0]), 64'(w0));
    check({tag, ".w1"},    64'(out_words[63:32]), 64'(w1));
    check({tag, ".wc"},    64'(out_wc), 64'(wc));
    check({tag, ".bub"},   64'(bubble_count), 64'(bub));
  endtask

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] ir;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [4:0]  wc;
    logic        ev;
    logic [31:0] eir;
    logic [31:0] ew0;
    logic [31:0] ew1;
    logic [4:0]  ewc;
    logic [15:0] ebub;
  } vec_t;

  vec_t vt[9];

  initial begin
    // Streaming/flush table, out_ready held at 1 throughout
    vt[0] = '{1'b0, 1'b1, 32'h00A1_0005, 32'h1111_1111, 32'h2222_2222, 5'd7,
              1'b1, 32'h00A1_0005, 32'h1111_1111, 32'h2222_2222, 5'd7, 16'd1};
    vt[1] = '{1'b0, 1'b1, 32'h0002_0013, 32'h3333_3333, 32'h4444_4444, 5'd3,
              1'b1, 32'h0002_0013, 32'h3333_3333, 32'h4444_4444, 5'd3, 16'd1};
    vt[2] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31,
              1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 16'd1};
    vt[3] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0,
              1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 16'd2};
    vt[4] = '{1'b0, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd31,
              1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd31, 16'd3};
    vt[5] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h5555_5555, 5'd9,
              1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 16'd3};
    vt[6] = '{1'b0, 1'b1, 32'h0000_0013, 32'h0000_0001, 32'h0000_0002, 5'd1,
              1'b1, 32'h0000_0013, 32'h0000_0001, 32'h0000_0002, 5'd1, 16'd4};
    vt[7] = '{1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0,
              1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 16'd4};
    vt[8] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0,
              1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 16'd5};

    // Saturation instance idles in reset until its own test
    s_reset = 1'b1; s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;
    s_in_ir = '0; s_in_words = '0; s_in_wc = '0;

    // Reset for two edges while an entry is offered
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 32'h00A1_0005, 32'h1111_1111, 32'h2222_2222, 5'd7);
    tick();
    tick();
    check_out("reset", 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 16'd0);
    check("reset.in_ready", 64'(in_ready), 64'(1));
    reset = 1'b0;

    // Table-driven streaming and flush
    for (int i = 0; i < 9; i++) begin
      flush = vt[i].fl;
      drive(vt[i].iv, vt[i].ir, vt[i].w0, vt[i].w1, vt[i].wc);
      tick();
      check_out($sformatf("vec%0d", i), vt[i].ev, vt[i].eir, vt[i].ew0, vt[i].ew1,
                vt[i].ewc, vt[i].ebub);
      check($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'(1));
    end
    flush = 1'b0;

    // Stall: X held while Y offered with out_ready low for 3 edges
    drive(1'b1, 32'hC0DE_0001, 32'hA0A0_A0A0, 32'hB0B0_B0B0, 5'd12);
    tick();
    check_out("stall.x", 1'b1, 32'hC0DE_0001, 32'hA0A0_A0A0, 32'hB0B0_B0B0, 5'd12, 16'd6);
    out_ready = 1'b0;
    drive(1'b1, 32'hC0DE_0002, 32'hC1C1_C1C1, 32'hD1D1_D1D1, 5'd13);
    #1;
`ifdef PIPE_LATCH_SKID_EN
    check("stall.pre_ready", 64'(in_ready), 64'(1));
`else
    check("stall.pre_ready", 64'(in_ready), 64'(0));
`endif
    tick();
    check_out("stall.e1", 1'b1, 32'hC0DE_0001, 32'hA0A0_A0A0, 32'hB0B0_B0B0, 5'd12, 16'd6);
    check("stall.e1.in_ready", 64'(in_ready), 64'(0));
`ifdef PIPE_LATCH_SKID_EN
    in_valid = 1'b0;  // Y now sits in the skid entry
`endif
    for (int i = 2; i <= 3; i++) begin
      tick();
      check_out($sformatf("stall.e%0d", i), 1'b1, 32'hC0DE_0001, 32'hA0A0_A0A0,
                32'hB0B0_B0B0, 5'd12, 16'd6);
      check($sformatf("stall.e%0d.in_ready", i), 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    tick();
    check_out("stall.y", 1'b1, 32'hC0DE_0002, 32'hC1C1_C1C1, 32'hD1D1_D1D1, 5'd13, 16'd6);
    check("stall.y.in_ready", 64'(in_ready), 64'(1));
    in_valid = 1'b0;
    tick();
    check_out("stall.drain", 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 16'd6);

    // Reset in the middle of a stall discards everything held
    drive(1'b1, 32'hC0DE_0003, 32'h0000_0033, 32'h0000_0034, 5'd20);
    tick();
    check_out("rstall.x", 1'b1, 32'hC0DE_0003, 32'h0000_0033, 32'h0000_0034, 5'd20, 16'd7);
    out_ready = 1'b0;
    drive(1'b1, 32'hC0DE_0004, 32'h0000_0044, 32'h0000_0045, 5'd21);
    tick();
    check_out("rstall.hold", 1'b1, 32'hC0DE_0003, 32'h0000_0033, 32'h0000_0034, 5'd20, 16'd7);
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    check_out("rstall.rst", 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 16'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    check_out("rstall.after", 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 16'd1);
    check("rstall.in_ready", 64'(in_ready), 64'(1));

    // Bubble counter saturation on the CNT_W=4 instance
    tick();
    check("sat.reset", 64'(s_bubble), 64'(0));
    s_reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("sat.k%0d", k), 64'(s_bubble), 64'((k > 15) ? 15 : k));
    end
    check("sat.valid", 64'(s_out_valid), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_latch.md
Name: pipe_stage_latch

Overview:
Parametrised pipeline-stage latch for the processor datapath. It generalises the fixed IR/O/D/wC inter-stage latches into one block with these parameters:
- configurable payload word count and width
- valid/ready handshake, so stalls propagate without a global write_enable
- flush that turns the held entry into a NOP bubble
- a saturating bubble counter for performance debug

It is instantiated between any two pipeline stages, for example X/M and M/W.

Parameters:
DATA_W, 32, width of the instruction word and of each payload word
NUM_WORDS, 2, number of payload words (e.g. O and D)
REG_W, 5, width of the destination register index (wC)
CNT_W, 16, width of bubble_count

Ports:
clk  input  1  pipeline clock; all state updates on the falling edge, matching the processor latch convention
reset  input  1  synchronous, active-high; sampled on the falling edge of clk
flush  input  1  discard held and incoming entries and insert a bubble
in_valid  input  1  upstream entry present
in_ready  output  1  latch can accept an entry this edge
in_ir  input  DATA_W  instruction word
in_words  input  NUM_WORDS*DATA_W  payload; word k occupies bits [k*DATA_W +: DATA_W]
in_wc  input  REG_W  destination register index
out_valid  output  1  downstream entry present
out_ready  input  1  downstream accepts this edge
out_ir  output  DATA_W  held instruction word
out_words  output  NUM_WORDS*DATA_W  held payload
out_wc  output  REG_W  held destination index
bubble_count  output  CNT_W  count of bubbles consumed downstream

Behaviour:
Events:
- in_fire = in_valid & in_ready at the edge
- out_fire = out_valid & out_ready at the edge

Priority per edge: reset > flush > normal operation.

Reset:
- out_valid=0, out_ir=0, out_words=0, out_wc=0, bubble_count=0.
- in_ready reads 1 in the first cycle after reset.
- Reset mid-stall discards all held entries.

Flush:
- out_valid<=0 and the held payload is zeroed (IR=0 is a NOP, wC=0 writes no register).
- Any entry accepted on the same edge (in_fire) is consumed and dropped.
- in_ready is not gated by flush.
- bubble_count still updates per its own rule.

Normal operation (single-entry mode):
- in_ready = out_ready | ~out_valid (combinational).
- If in_ready: out_valid<=in_valid. Payload <= in_* when in_valid, else zeroed.
- If ~in_ready (out_valid & ~out_ready): all state holds. This is a stall, and in_* is ignored.

Latency and throughput: exactly one falling edge from in_fire to out_valid; one entry per cycle with no bubbles when out_ready stays high.

Payload rules:
- Payload is passed bit-exact; no width conversion.
- Whenever out_valid=0, out_ir, out_words and out_wc are all 0.

bubble_count:
- Increments by 1 on each edge with out_ready=1 and out_valid=0.
- Saturates at 2^CNT_W-1; it does not wrap.
- Cleared only by reset.

Optional Feature:
PIPE_LATCH_SKID_EN

Defined:
- Adds a second (skid) entry and makes in_ready a registered signal: in_ready = ~skid_valid.
- in_fire while main is valid and not draining: the entry goes to skid.
- out_fire with skid_valid: skid moves to main; if in_fire also occurs, the new entry goes to skid.
- in_ready rises on the edge after skid drains.
- Ordering is strictly FIFO. Latency stays one edge when skid is empty.
- Flush and reset clear both entries.

Undefined:
- Single-entry behaviour as above.
- in_ready is combinational from out_ready.

Test Plan:
1. Reset: hold reset=1 for 2 edges with in_valid=1 -> out_valid=0, out_ir=0, out_wc=0, bubble_count=0; in_ready=1 after release.
2. Streaming: out_ready=1; send IR=0x00A1_0005, words {0x1111_1111, 0x2222_2222}, wC=7, then the next entry on consecutive edges -> each appears one edge later; out_wc=7 on the first; no bubbles and bubble_count unchanged.
3. Stall: hold out_ready=0 for 3 edges while entry X is held and Y is offered -> X stays stable and in_ready=0 (non-skid); on out_ready=1, X fires, then Y follows next edge.
4. Flush: flush=1 on the edge where Y is accepted -> out_valid=0, out_ir=0, out_wc=0; Y never appears; the next entry Z passes normally.
5. Bubble saturation: CNT_W=4, out_ready=1, in_valid=0 for 20 edges -> bubble_count reaches 15 and holds.
6. PIPE_LATCH_SKID_EN: out_ready=0 with A held and B offered -> B is accepted into skid and in_ready drops next cycle; release out_ready -> outputs A then B in order; in_ready returns to 1.
